// File: rtl/score_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : score_tracker                                              |
// | Description : Game-side score accumulator. Counts hit/miss events while  |
// |               a round is being played, applies a saturating combo        |
// |               multiplier and keeps a session high score for the          |
// |               seven-segment display path.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           in   1   system clock, rising edge                        |
// |   reset         in   1   synchronous active-high reset                    |
// |   game_start    in   1   pulse: begin / restart a round                   |
// |   game_over     in   1   pulse: end the current round                     |
// |   hit_valid     in   1   pulse: scoring event                             |
// |   hit_points    in   8   base points, sampled with hit_valid              |
// |   miss          in   1   pulse: missed event                              |
// |   score         out  16  current round score (saturating)                 |
// |   high_score    out  16  best score since reset                           |
// |   combo         out  4   current multiplier, 1..MAX_COMBO                 |
// |   playing       out  1   high while a round is in progress                |
// |   score_changed out  1   one-cycle pulse when score took a new value      |
// | Build option                                                             |
// |   SCORE_PENALTY_EN : when defined, a miss subtracts PENALTY (floor 0)    |
// +--------------------------------------------------------------------------+
module score_tracker #(
  parameter int MAX_COMBO = 8,
  parameter int PENALTY   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        hit_valid,
  input  logic [7:0]  hit_points,
  input  logic        miss,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [3:0]  combo,
  output logic        playing,
  output logic        score_changed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  localparam logic [3:0]  c_max_combo = 4'(MAX_COMBO);
  localparam logic [15:0] c_penalty   = 16'(PENALTY);

  // Out-of-range parameters stop elaboration instead of silently truncating.
  generate
    if (MAX_COMBO < 1 || MAX_COMBO > 15 || PENALTY < 0 || PENALTY > 65535) begin : g_param_check
      $error("score_tracker: parameter out of range");
    end
  endgenerate

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_score;
  logic [15:0] w_next_score;
  logic [3:0]  r_combo;
  logic [3:0]  w_next_combo;
  logic [15:0] r_high_score;
  logic        r_playing;
  logic        r_score_changed;
  logic        r_hs_pending;   // set for the first cycle spent in OVER

  logic [11:0] w_hit_product;
  logic [16:0] w_hit_sum;
  logic [15:0] w_hit_score;
  logic [3:0]  w_combo_inc;
  logic [15:0] w_miss_score;

  // 255 * 15 fits in 12 bits; the sum carries one extra bit for saturation.
  assign w_hit_product = {4'd0, hit_points} * {8'd0, r_combo};
  assign w_hit_sum     = {1'b0, r_score} + {5'd0, w_hit_product};
  assign w_hit_score   = w_hit_sum[16] ? 16'hFFFF : w_hit_sum[15:0];
  assign w_combo_inc   = (r_combo >= c_max_combo) ? c_max_combo : r_combo + 4'd1;

`ifdef SCORE_PENALTY_EN
  assign w_miss_score  = (r_score > c_penalty) ? r_score - c_penalty : 16'd0;
`else
  assign w_miss_score  = r_score;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_score = r_score;
    w_next_combo = r_combo;
    case (r_state)
      ST_PLAYING: begin
        if (game_start) begin
          // Restart wins over any event or game_over in the same cycle.
          w_next_score = 16'd0;
          w_next_combo = 4'd1;
        end else begin
          // Events are applied before the round closes on the same edge.
          if (miss) begin
            w_next_score = w_miss_score;
            w_next_combo = 4'd1;
          end else if (hit_valid) begin
            w_next_score = w_hit_score;
            w_next_combo = w_combo_inc;
          end
          if (game_over) begin
            w_next_state = ST_OVER;
          end
        end
      end
      default: begin
        // IDLE and OVER ignore everything except game_start.
        if (game_start) begin
          w_next_state = ST_PLAYING;
          w_next_score = 16'd0;
          w_next_combo = 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_score         <= 16'd0;
      r_combo         <= 4'd1;
      r_high_score    <= 16'd0;
      r_playing       <= 1'b0;
      r_score_changed <= 1'b0;
      r_hs_pending    <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_score         <= w_next_score;
      r_combo         <= w_next_combo;
      r_playing       <= (w_next_state == ST_PLAYING);
      r_score_changed <= (w_next_score != r_score);
      r_hs_pending    <= (r_state == ST_PLAYING) && (w_next_state == ST_OVER);
      // Compare the settled final score once, on the first OVER cycle.
      if (r_hs_pending && (r_score > r_high_score)) begin
        r_high_score <= r_score;
      end
    end
  end

  assign score         = r_score;
  assign high_score    = r_high_score;
  assign combo         = r_combo;
  assign playing       = r_playing;
  assign score_changed = r_score_changed;

endmodule
`default_nettype wire
